// File: rtl/plusarg_watchdog.sv
//------------------------------------------------------------------------------
// Module      : plusarg_watchdog
// Description : No-progress watchdog driven by a plusarg cycle limit.
//               It warns at 7/8 of the limit and trips with a sticky timeout.
//               Optional macro PLUSARG_WATCHDOG_FATAL_EN ends simulation on trip.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module plusarg_watchdog #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [31:0]      limit,
  input  logic             enable,
  input  logic             kick,
  input  logic             clear,
  output logic             armed,
  output logic             warn,
  output logic             timeout,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] c_one = WIDTH'(1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_WARN    = 2'd2,
    S_TRIPPED = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] w_count_nxt;
  logic [WIDTH-1:0] w_count_inc;
  logic [WIDTH-1:0] r_lim;
  logic [WIDTH-1:0] r_warn_th;
  logic [WIDTH-1:0] w_lim_in;
  logic             w_load;

  assign w_lim_in    = WIDTH'(limit);
  assign w_count_inc = r_count + c_one;

  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_load      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (enable && (w_lim_in != '0)) begin
          w_state_nxt = S_ARMED;
          w_count_nxt = '0;
          w_load      = 1'b1;
        end
      end
      S_ARMED, S_WARN: begin
        if (!enable) begin
          w_state_nxt = S_IDLE;
          w_count_nxt = '0;
        end else if (kick) begin
          w_state_nxt = S_ARMED;
          w_count_nxt = '0;
        end else if (r_count == (r_lim - c_one)) begin
          // count freezes at lim_q-1 so it can never wrap
          w_state_nxt = S_TRIPPED;
        end else begin
          w_count_nxt = w_count_inc;
          if (w_count_inc >= r_warn_th) begin
            w_state_nxt = S_WARN;
          end
        end
      end
      S_TRIPPED: begin
        if (clear) begin
          w_state_nxt = S_IDLE;
          w_count_nxt = '0;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_count_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_count   <= '0;
      r_lim     <= '0;
      r_warn_th <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      if (w_load) begin
        r_lim     <= w_lim_in;
        // lim - lim/8 equals lim for lim < 8, so tiny limits never warn
        r_warn_th <= w_lim_in - (w_lim_in >> 3);
      end
    end
  end

  assign armed   = (r_state == S_ARMED) || (r_state == S_WARN);
  assign warn    = (r_state == S_WARN);
  assign timeout = (r_state == S_TRIPPED);
  assign count   = r_count;

`ifdef PLUSARG_WATCHDOG_FATAL_EN
`ifndef SYNTHESIS
  always @(posedge clock) begin
    if (reset_n && (r_state != S_TRIPPED) && (w_state_nxt == S_TRIPPED)) begin
      $display("[%0t] plusarg_watchdog: timeout lim_q=%0d state=%s",
               $time, r_lim, r_state.name());
      $fatal(1, "plusarg_watchdog: no progress within %0d cycles", r_lim);
    end
  end
`endif
`endif

endmodule

`default_nettype wire
